// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug dump path.
//   NUM_REGS / ADDR_W / DATA_W : default geometry of the RV32I register file
//   dump_state_t               : dump controller FSM encoding
//   dump_word_t                : one {addr,data} word as carried on the debug link
package rf_dbg_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dump_word_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
// Walks an inclusive, possibly wrapping, range of architectural registers through
// one combinational regfile read port and streams {addr,data} words to the debug link.
// o_busy stalls the CPU so the register contents stay frozen while the dump runs.
//
// Ports
//   i_clk, i_reset_n            clock (posedge) and asynchronous active-low reset
//   i_start                     dump request, only looked at in IDLE
//   i_first_addr, i_last_addr   inclusive range, captured together with i_start
//   o_rf_addr / i_rf_data       regfile read port (data is combinational from addr)
//   o_dump_valid/i_dump_ready   output word handshake
//   o_dump_addr, o_dump_data    current output word
//   o_busy                      high in READ and SEND; CPU stall request
//   o_done                      one-cycle pulse after the last word is accepted
//   o_dbg_state                 current FSM state, for debug and assertion binding
//
// Handshake: a word transfers on a rising edge where o_dump_valid && i_dump_ready.
// Once o_dump_valid rises, o_dump_addr/o_dump_data stay constant and o_dump_valid
// stays high until that transfer happens (only reset can withdraw it).
module regfile_dump_ctrl
  import rf_dbg_pkg::*;
#(
  parameter int NUM_REGS = rf_dbg_pkg::NUM_REGS,
  parameter int ADDR_W   = rf_dbg_pkg::ADDR_W,
  parameter int DATA_W   = rf_dbg_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  dump_state_t       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic [DATA_W-1:0] word_data_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] ptr_next;

  // Modulo NUM_REGS increment; with a power-of-two register count this is just
  // the natural ADDR_W-bit wrap (31 -> 0).
  assign ptr_next = ADDR_W'((32'(ptr_q) + 32'd1) % NUM_REGS);

  // The read address is the pointer itself: it is what READ needs, and in the
  // other states it simply holds the last value so the regfile port stays quiet.
  assign o_rf_addr    = ptr_q;
  assign o_dump_addr  = word_addr_q;
  assign o_dump_data  = word_data_q;
  assign o_dump_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_dbg_state  = state_q;

  // Output flags are registered alongside the state so that each one is a pure
  // function of the state being entered: busy in READ/SEND, valid in SEND, done in DONE.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      end_q       <= '0;
      word_addr_q <= '0;
      word_data_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            ptr_q   <= i_first_addr;
            end_q   <= i_last_addr;
            busy_q  <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          // Capture the word once; SEND never re-reads, so a stalled word is stable.
          word_addr_q <= ptr_q;
          word_data_q <= i_rf_data;
          valid_q     <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (i_dump_ready) begin
            valid_q <= 1'b0;
            if (ptr_q == end_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              ptr_q   <= ptr_next;
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
